// File: rtl/cpu_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_responder
// Brief    : CPU bus responder with mirrored work RAM, open-bus latch,
//            external pass-through port and a 256-byte OAM DMA engine.
// Revision : 1.0  initial release
// ============================================================================
module cpu_bus_responder #(
    parameter int          RAM_AW  = 11,
    parameter logic [15:0] DMA_REG = 16'h4014
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        rw,
    inout  wire  [7:0]  data,
    output logic        cpu_halt,
    output logic        ext_en,
    output logic        ext_rw,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_wdata
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ALIGN = 2'd1;
    localparam logic [1:0] c_READ  = 2'd2;
    localparam logic [1:0] c_WRITE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        r_halt;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_byte;
    logic [7:0]  r_open_bus;
    logic [7:0]  r_ram [0:(2**RAM_AW)-1];

    logic        w_sel_ram;
    logic        w_sel_dma;
    logic        w_sel_ext;
    logic        w_cpu_own;
    logic        w_cpu_wr;
    logic [7:0]  w_rd_data;
    logic [7:0]  w_bus_val;
    logic [15:0] w_dma_addr;
    logic [7:0]  w_dma_src;

    // ---------------- CPU-side decode ----------------
    assign w_sel_ram = (addr[15:13] == 3'b000);
    assign w_sel_dma = (addr == DMA_REG);
    assign w_sel_ext = !w_sel_ram && !w_sel_dma;
    assign w_cpu_own = !r_halt;
    assign w_cpu_wr  = w_cpu_own && !rw;

    always_comb begin
        w_rd_data = ext_rdata;
        if (w_sel_ram)
            w_rd_data = r_ram[addr[RAM_AW-1:0]];
        else if (w_sel_dma)
            w_rd_data = r_open_bus;
    end

    assign data      = (rw && w_cpu_own) ? w_rd_data : 8'bz;
    assign w_bus_val = rw ? w_rd_data : data;

    // ---------------- DMA source selection ----------------
    assign w_dma_addr = {r_page, r_idx};
    assign w_dma_src  = (r_page[7:5] == 3'b000) ? r_ram[w_dma_addr[RAM_AW-1:0]]
                                                 : ext_rdata;

    // ---------------- State register and datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_halt     <= 1'b0;
            r_page     <= 8'h00;
            r_idx      <= 8'h00;
            r_byte     <= 8'h00;
            r_open_bus <= 8'h00;
        end else begin
            r_state <= w_next;
            r_halt  <= (w_next != c_IDLE);
            // While halted nobody drives the bus, so the latch keeps its value.
            if (w_cpu_own)
                r_open_bus <= w_bus_val;
            case (r_state)
                c_IDLE: begin
                    if (w_cpu_wr && w_sel_dma) begin
                        r_page <= data;
                        r_idx  <= 8'h00;
                    end
                end
                c_READ:  r_byte <= w_dma_src;
                c_WRITE: r_idx  <= r_idx + 8'd1;
                default: ;
            endcase
        end
    end

    // Work RAM is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && w_cpu_wr && w_sel_ram)
            r_ram[addr[RAM_AW-1:0]] <= data;
    end

    // ---------------- Next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_cpu_wr && w_sel_dma) w_next = c_ALIGN;
            c_ALIGN: w_next = c_READ;
            c_READ:  w_next = c_WRITE;
            c_WRITE: w_next = (r_idx == 8'hFF) ? c_IDLE : c_READ;
            default: w_next = c_IDLE;
        endcase
    end

    // ---------------- Output logic ----------------
    always_comb begin
        ext_en    = 1'b0;
        ext_rw    = 1'b1;
        ext_addr  = addr;
        ext_wdata = data;
        oam_we    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_sel_ext) begin
                    ext_en = 1'b1;
                    ext_rw = rw;
                end
            end
            c_READ: begin
                ext_en    = (r_page[7:5] != 3'b000);
                ext_addr  = w_dma_addr;
                ext_wdata = 8'h00;
            end
            c_WRITE: oam_we = 1'b1;
            default: ;
        endcase
    end

    assign cpu_halt  = r_halt;
    assign oam_wdata = r_byte;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_bus_responder
// Brief    : Directed self-checking bench for cpu_bus_responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_bus_responder;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  tb_wdata;
    logic        tb_drive;
    wire  [7:0]  data;
    logic        cpu_halt;
    logic        ext_en;
    logic        ext_rw;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    logic        ext_mode;
    logic [7:0]  ext_const;

    int nchk = 0;
    int nbad = 0;

    assign data = tb_drive ? tb_wdata : 8'bz;

    always_comb ext_rdata = ext_mode ? ext_addr[7:0] : ext_const;

    cpu_bus_responder #(.RAM_AW(11), .DMA_REG(16'h4014)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .rw        (rw),
        .data      (data),
        .cpu_halt  (cpu_halt),
        .ext_en    (ext_en),
        .ext_rw    (ext_rw),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .oam_we    (oam_we),
        .oam_wdata (oam_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        addr     = a;
        rw       = 1'b0;
        tb_wdata = d;
        tb_drive = 1'b1;
        tick();
        tb_drive = 1'b0;
        rw       = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        addr  = 16'h4014;
        rw    = 1'b1;
        tick();
        tick();
        @(negedge clk);
        nchk++; if (cpu_halt !== 1'b0) begin nbad++; $display("FAIL reset_halt got=%b exp=0", cpu_halt); end
        nchk++; if (oam_we !== 1'b0) begin nbad++; $display("FAIL reset_oam_we got=%b exp=0", oam_we); end
        nchk++; if (oam_wdata !== 8'h00) begin nbad++; $display("FAIL reset_oam_wdata got=%h exp=00", oam_wdata); end
        nchk++; if (data !== 8'h00) begin nbad++; $display("FAIL reset_open_bus got=%h exp=00", data); end
        addr = 16'h0000;
        #1;
        nchk++; if (ext_en !== 1'b0) begin nbad++; $display("FAIL reset_ext_en got=%b exp=0", ext_en); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ram_mirror;
        logic [15:0] mirrors [3];
        mirrors[0] = 16'h0812;
        mirrors[1] = 16'h1012;
        mirrors[2] = 16'h1812;
        cpu_write(16'h0012, 8'h5A);
        for (int k = 0; k < 3; k++) begin
            addr = mirrors[k];
            rw   = 1'b1;
            @(negedge clk);
            nchk++; if (data !== 8'h5A) begin nbad++; $display("FAIL ram_mirror addr=%h got=%h exp=5a", mirrors[k], data); end
            nchk++; if (ext_en !== 1'b0) begin nbad++; $display("FAIL ram_mirror_ext_en addr=%h got=%b exp=0", mirrors[k], ext_en); end
            tick();
        end
    endtask

    task automatic test_ext;
        ext_mode  = 1'b0;
        ext_const = 8'h80;
        addr      = 16'h2002;
        rw        = 1'b1;
        @(negedge clk);
        nchk++; if (data !== 8'h80) begin nbad++; $display("FAIL ext_read_data got=%h exp=80", data); end
        nchk++; if (ext_en !== 1'b1 || ext_rw !== 1'b1) begin nbad++; $display("FAIL ext_read_ctl got en=%b rw=%b exp en=1 rw=1", ext_en, ext_rw); end
        nchk++; if (ext_addr !== 16'h2002) begin nbad++; $display("FAIL ext_read_addr got=%h exp=2002", ext_addr); end
        tick();
        addr     = 16'h2006;
        rw       = 1'b0;
        tb_wdata = 8'h3F;
        tb_drive = 1'b1;
        @(negedge clk);
        nchk++; if (ext_wdata !== 8'h3F) begin nbad++; $display("FAIL ext_write_data got=%h exp=3f", ext_wdata); end
        nchk++; if (ext_en !== 1'b1 || ext_rw !== 1'b0) begin nbad++; $display("FAIL ext_write_ctl got en=%b rw=%b exp en=1 rw=0", ext_en, ext_rw); end
        tick();
        tb_drive = 1'b0;
        rw       = 1'b1;
    endtask

    task automatic test_open_bus;
        cpu_write(16'h0000, 8'h77);
        addr = 16'h4014;
        rw   = 1'b1;
        @(negedge clk);
        nchk++; if (data !== 8'h77) begin nbad++; $display("FAIL open_bus got=%h exp=77", data); end
        nchk++; if (ext_en !== 1'b0) begin nbad++; $display("FAIL open_bus_ext_en got=%b exp=0", ext_en); end
        tick();
    endtask

    // Triggers a DMA of one page and checks halt length, pulse timing and data.
    task automatic run_dma(input logic [7:0] page, input logic ext_src);
        int          halt_cnt;
        int          pulses;
        bit          done;
        logic [7:0]  exp_b;
        logic [15:0] exp_a;
        cpu_write(16'h4014, page);
        // Hostile CPU writes during halt must not reach RAM.
        addr     = 16'h0200;
        rw       = 1'b0;
        tb_wdata = 8'hFF;
        tb_drive = 1'b1;
        halt_cnt = 0;
        pulses   = 0;
        done     = 1'b0;
        for (int cyc = 0; cyc < 700 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                nchk++; if (cpu_halt !== 1'b1) begin nbad++; $display("FAIL dma_halt_start page=%h got=%b exp=1", page, cpu_halt); end
            end
            if (cpu_halt === 1'b1) begin
                halt_cnt++;
                if (halt_cnt >= 2 && (halt_cnt % 2) == 0) begin
                    exp_a = {page, 8'((halt_cnt - 2) / 2)};
                    nchk++;
                    if (ext_en !== ext_src || oam_we !== 1'b0 || (ext_src && ext_addr !== exp_a)) begin
                        nbad++;
                        $display("FAIL dma_read_cycle n=%0d got en=%b we=%b addr=%h exp en=%b we=0 addr=%h",
                                 halt_cnt, ext_en, oam_we, ext_addr, ext_src, exp_a);
                    end
                end
                if (oam_we === 1'b1) begin
                    exp_b = ext_src ? 8'(pulses) : (8'(pulses) ^ 8'hA5);
                    nchk++; if (oam_wdata !== exp_b) begin nbad++; $display("FAIL dma_oam_data idx=%0d got=%h exp=%h", pulses, oam_wdata, exp_b); end
                    if (pulses == 0) begin
                        nchk++; if (halt_cnt != 3) begin nbad++; $display("FAIL dma_first_pulse got=%0d exp=3", halt_cnt); end
                    end
                    pulses++;
                end
            end else begin
                done     = 1'b1;
                rw       = 1'b1;
                tb_drive = 1'b0;
                addr     = 16'h0000;
            end
        end
        rw       = 1'b1;
        tb_drive = 1'b0;
        nchk++; if (!done) begin nbad++; $display("FAIL dma_timeout page=%h got=halt_stuck exp=release", page); end
        nchk++; if (halt_cnt != 513) begin nbad++; $display("FAIL dma_halt_len page=%h got=%0d exp=513", page, halt_cnt); end
        nchk++; if (pulses != 256) begin nbad++; $display("FAIL dma_pulses page=%h got=%0d exp=256", page, pulses); end
        tick();
    endtask

    task automatic test_dma_ram;
        for (int i = 0; i < 256; i++)
            cpu_write(16'h0200 + 16'(i), 8'(i) ^ 8'hA5);
        run_dma(8'h02, 1'b0);
        addr = 16'h0200;
        rw   = 1'b1;
        @(negedge clk);
        nchk++; if (data !== 8'hA5) begin nbad++; $display("FAIL dma_ram_protect got=%h exp=a5", data); end
        tick();
    endtask

    task automatic test_dma_ext;
        ext_mode = 1'b1;
        run_dma(8'h80, 1'b1);
        ext_mode = 1'b0;
    endtask

    task automatic test_reset_mid_dma;
        int halt_cnt;
        bit hit;
        bit stray;
        cpu_write(16'h4014, 8'h02);
        halt_cnt = 0;
        hit      = 1'b0;
        for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
            @(negedge clk);
            if (cpu_halt === 1'b1) halt_cnt++;
            if (halt_cnt == 100) begin
                reset = 1'b1;
                hit   = 1'b1;
            end
        end
        nchk++; if (!hit) begin nbad++; $display("FAIL mid_reset_reach got=%0d exp=100", halt_cnt); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        nchk++; if (cpu_halt !== 1'b0) begin nbad++; $display("FAIL mid_reset_halt got=%b exp=0", cpu_halt); end
        nchk++; if (oam_we !== 1'b0) begin nbad++; $display("FAIL mid_reset_oam_we got=%b exp=0", oam_we); end
        stray = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (oam_we !== 1'b0 || cpu_halt !== 1'b0) stray = 1'b1;
        end
        nchk++; if (stray) begin nbad++; $display("FAIL mid_reset_stray got=activity exp=quiet"); end
        tick();
        run_dma(8'h02, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        addr      = 16'h0000;
        rw        = 1'b1;
        tb_wdata  = 8'h00;
        tb_drive  = 1'b0;
        ext_mode  = 1'b0;
        ext_const = 8'h00;
        test_reset();
        test_ram_mirror();
        test_ext();
        test_open_bus();
        test_dma_ram();
        test_dma_ext();
        test_reset_mid_dma();
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
`default_nettype wire
